sprite_draw_engine: RTL and testbench

Executes the CHIP-8 CLS and DRW operations issued by the `cpu` and owns the 64x32 monochrome framebuffer. It accepts a draw request carrying the X/Y coordinates, row count and up to 15 sprite bytes. It XORs the sprite into the framebuffer one row per cycle, reports the collision flag back for VF, and exposes a registered row-read port for display scan-out.

---
 rtl/veri8_pkg.sv | 20 ++
 rtl/sprite_row_place.sv | 21 ++
 rtl/sprite_draw_engine.sv | 131 +++++++++++++
 tb/tb_sprite_draw_engine.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/veri8_pkg.sv
// Shared constants and types for the sprite draw engine.
// The framebuffer is a 32-row array, 64 pixels per row.
package veri8_pkg;

    localparam int FB_W     = 64;
    localparam int FB_H     = 32;
    localparam int MAX_ROWS = 15;

    localparam int ROW_AW = $clog2(FB_H);
    localparam int COL_AW = $clog2(FB_W);
    localparam int SPR_W  = 8 * MAX_ROWS;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAW,
        DONE
    } draw_state_t;

endpackage

// File: rtl/sprite_row_place.sv
// Places one sprite byte at column x of a framebuffer row, wrapping horizontally.
// Bit W-1 of the mask is pixel x=0.
module sprite_row_place
    import veri8_pkg::*;
#(
    parameter int W  = FB_W,
    parameter int XW = $clog2(W)
) (
    input  logic [7:0]    spr_byte,
    input  logic [XW-1:0] x,
    output logic [W-1:0]  mask
);

    logic [W-1:0] placed;

    assign placed = {spr_byte, {(W-8){1'b0}}};

    // Rotate right by x; at x=0 the left shift amount equals W and yields zero.
    assign mask = (placed >> x) | (placed << (W - int'(x)));

endmodule

// File: rtl/sprite_draw_engine.sv
// CHIP-8 CLS/DRW executor owning the 64x32 framebuffer.
// One framebuffer row is cleared or XOR-drawn per cycle; registered scan-out read port.
module sprite_draw_engine
    import veri8_pkg::draw_state_t, veri8_pkg::IDLE, veri8_pkg::CLEAR,
           veri8_pkg::DRAW, veri8_pkg::DONE;
#(
    parameter int FB_W     = veri8_pkg::FB_W,
    parameter int FB_H     = veri8_pkg::FB_H,
    parameter int MAX_ROWS = veri8_pkg::MAX_ROWS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_req,
    input  logic                      draw_req,
    input  logic [7:0]                vx,
    input  logic [7:0]                vy,
    input  logic [3:0]                n_bits,
    input  logic [8*MAX_ROWS-1:0]     sprite_data,
    output logic                      busy,
    output logic                      done,
    output logic                      collision,
    input  logic [$clog2(FB_H)-1:0]   rd_row,
    output logic [FB_W-1:0]           rd_data
);

    localparam int RAW = $clog2(FB_H);
    localparam int CAW = $clog2(FB_W);

    draw_state_t           state;
    logic [RAW-1:0]        cnt;
    logic [CAW-1:0]        lat_x;
    logic [RAW-1:0]        lat_y;
    logic [3:0]            lat_n;
    logic [8*MAX_ROWS-1:0] lat_spr;
    logic [FB_W-1:0]       fb [FB_H];

    logic [7:0]      spr_byte;
    logic [FB_W-1:0] mask;
    logic [RAW-1:0]  tgt;
    logic [FB_W-1:0] old_row;
    logic [FB_W-1:0] new_row;
    logic            hit;
    logic            last_draw;
    logic            last_clear;

    always_comb begin
        spr_byte = '0;
        for (int k = 0; k < MAX_ROWS; k++) begin
            if (cnt == RAW'(k)) spr_byte = lat_spr[8*(MAX_ROWS-1-k) +: 8];
        end
    end

    sprite_row_place #(.W(FB_W), .XW(CAW)) u_place (
        .spr_byte (spr_byte),
        .x        (lat_x),
        .mask     (mask)
    );

    // Row address wraps naturally in RAW bits; a wrapped row reads its already-updated value.
    assign tgt        = (state == DRAW) ? lat_y + cnt : cnt;
    assign old_row    = fb[tgt];
    assign new_row    = (state == CLEAR) ? '0 : (old_row ^ mask);
    assign hit        = |(old_row & mask);
    assign last_draw  = (cnt + RAW'(1)) == RAW'(lat_n);
    assign last_clear = cnt == RAW'(FB_H - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_n     <= '0;
            lat_spr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            rd_data   <= '0;
            for (int r = 0; r < FB_H; r++) fb[r] <= '0;
        end else begin
            rd_data <= fb[rd_row];
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // Clear wins when both requests arrive together.
                    if (clear_req) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        collision <= 1'b0;
                    end else if (draw_req) begin
                        lat_x     <= CAW'(int'(vx) % FB_W);
                        lat_y     <= RAW'(int'(vy) % FB_H);
                        lat_n     <= n_bits;
                        lat_spr   <= sprite_data;
                        collision <= 1'b0;
                        if (n_bits == 4'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAW;
                            busy  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    fb[tgt] <= new_row;
                    cnt     <= cnt + RAW'(1);
                    if (last_clear) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DRAW: begin
                    fb[tgt] <= new_row;
                    cnt     <= cnt + RAW'(1);
                    if (hit) collision <= 1'b1;
                    if (last_draw) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: draws, wraps, clear priority, reset abort.
module tb_sprite_draw_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_req;
    logic         draw_req;
    logic [7:0]   vx;
    logic [7:0]   vy;
    logic [3:0]   n_bits;
    logic [119:0] sprite_data;
    logic         busy;
    logic         done;
    logic         collision;
    logic [4:0]   rd_row;
    logic [63:0]  rd_data;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sprite_draw_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req   (clear_req),
        .draw_req    (draw_req),
        .vx          (vx),
        .vy          (vy),
        .n_bits      (n_bits),
        .sprite_data (sprite_data),
        .busy        (busy),
        .done        (done),
        .collision   (collision),
        .rd_row      (rd_row),
        .rd_data     (rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; the request is sampled at the next edge (cycle 0).
    task automatic issue(input logic clr, input logic drw, input logic [7:0] x,
                         input logic [7:0] y, input logic [3:0] n, input logic [119:0] d);
        clear_req   = clr;
        draw_req    = drw;
        vx          = x;
        vy          = y;
        n_bits      = n;
        sprite_data = d;
        @(posedge clk); #1;
        clear_req   = 1'b0;
        draw_req    = 1'b0;
        vx          = 8'hA5;
        vy          = 8'h5A;
        n_bits      = 4'hF;
        sprite_data = {15{8'hFF}};
    endtask

    task automatic wait_done(input string tag, input int start, input int exp_cyc,
                             input logic exp_col);
        int   cyc     = start;
        logic busy_ok = 1'b1;
        while (!done && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " busy_before_done"}, 64'(busy_ok), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " collision"}, 64'(collision), 64'(exp_col));
        @(posedge clk); #1;
    endtask

    task automatic rd(input int r, output logic [63:0] v);
        rd_row = 5'(r);
        @(posedge clk); #1;
        v = rd_data;
    endtask

    task automatic chk_all_zero(input string tag);
        logic [63:0] v;
        for (int r = 0; r < 32; r++) begin
            rd(r, v);
            chk($sformatf("%s row%0d", tag, r), v, 64'h0);
        end
    endtask

    initial begin
        logic [63:0] v;
        logic        saw_done;

        rst_n = 1'b0; clear_req = 1'b0; draw_req = 1'b0;
        vx = '0; vy = '0; n_bits = '0; sprite_data = '0; rd_row = '0;
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset collision", 64'(collision), 64'd0);
        chk("reset rd_data", rd_data, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("reset");

        // Single full byte at origin, then the same draw erases it with collision.
        issue(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, {8'hFF, 112'h0});
        wait_done("draw1", 1, 2, 1'b0);
        rd(0, v); chk("draw1 row0", v, 64'hFF00_0000_0000_0000);
        issue(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, {8'hFF, 112'h0});
        wait_done("draw2", 1, 2, 1'b1);
        rd(0, v); chk("draw2 row0", v, 64'h0);

        // Horizontal wrap, then vx=70 behaving as vx=6 on the same row.
        issue(1'b0, 1'b1, 8'd60, 8'd5, 4'd1, {8'hFF, 112'h0});
        wait_done("hwrap60", 1, 2, 1'b0);
        rd(5, v); chk("hwrap60 row5", v, 64'hF000_0000_0000_000F);
        issue(1'b0, 1'b1, 8'd70, 8'd5, 4'd1, {8'hFF, 112'h0});
        wait_done("hwrap70", 1, 2, 1'b0);
        rd(5, v); chk("hwrap70 row5", v, 64'hF3FC_0000_0000_000F);

        // Vertical wrap from row 30 into rows 0 and 1.
        issue(1'b0, 1'b1, 8'd0, 8'd30, 4'd4, {8'h80, 8'h40, 8'h20, 8'h10, 88'h0});
        wait_done("vwrap", 1, 5, 1'b0);
        rd(30, v); chk("vwrap row30", v, 64'h8000_0000_0000_0000);
        rd(31, v); chk("vwrap row31", v, 64'h4000_0000_0000_0000);
        rd(0, v);  chk("vwrap row0",  v, 64'h2000_0000_0000_0000);
        rd(1, v);  chk("vwrap row1",  v, 64'h1000_0000_0000_0000);

        // Clear and draw together: clear wins; a draw during the clear is dropped.
        issue(1'b1, 1'b1, 8'd0, 8'd0, 4'd1, {8'hFF, 112'h0});
        draw_req = 1'b1; vx = 8'd8; vy = 8'd10; n_bits = 4'd2; sprite_data = {16'hFFFF, 104'h0};
        @(posedge clk); #1;
        draw_req = 1'b0;
        wait_done("clear", 2, 33, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("clear idle busy", 64'(busy), 64'd0);
        chk_all_zero("clear");

        // Reset in cycle 3 of an 8-row draw that already collided on row 0.
        issue(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, {8'hFF, 112'h0});
        wait_done("prepop", 1, 2, 1'b0);
        issue(1'b0, 1'b1, 8'd0, 8'd0, 4'd8, {{8{8'hFF}}, 56'h0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst pre busy", 64'(busy), 64'd1);
        chk("midrst pre collision", 64'(collision), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        chk("midrst collision", 64'(collision), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst no done", 64'(saw_done), 64'd0);
        chk_all_zero("midrst");

        // Zero-height sprite completes immediately with no collision.
        issue(1'b0, 1'b1, 8'd3, 8'd3, 4'd0, {8'hFF, 112'h0});
        wait_done("n0", 1, 1, 1'b0);
        rd(3, v); chk("n0 row3", v, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
